tdoa_pixel_locator: RTL and testbench

//  Parametrised successor to the 6+1-mic position solver. Converts six signed

---
 rtl/tdoa_pixel_locator.sv | 238 +++++++++++++++++++++++
 tb/tb_tdoa_pixel_locator.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tdoa_pixel_locator.sv
// tdoa_pixel_locator: six TDOA lags -> distances -> range/position -> camera pixel (u,v).
// Define TDOA_PIXEL_CLAMP_EN to saturate out-of-frame pixels instead of flagging them.
module tdoa_pixel_locator #(
    parameter int LAG_W = 6,
    parameter int DW    = 32,
    parameter int OW    = 12,
    parameter int MIC_L = 200,
    parameter int VEL   = 340,
    parameter int FS    = 93750,
    parameter int FX    = 437,
    parameter int FY    = 330,
    parameter int CX    = 242,
    parameter int CY    = 145,
    parameter int IMG_W = 480,
    parameter int IMG_H = 272
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [6*LAG_W-1:0] lag_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OW-1:0]     out_u,
    output logic [OW-1:0]     out_v,
    output logic              out_err,
    output logic [1:0]        err_code
);
    localparam int CW = $clog2(DW);
    localparam int HW = DW / 2;
    typedef logic signed [DW-1:0] sdw_t;
    localparam sdw_t K_SCALE = sdw_t'(VEL * 10000);
    localparam sdw_t K_FS    = sdw_t'(FS);
    localparam sdw_t K_XDEN  = sdw_t'(8 * 1732 * MIC_L / 100);
    localparam sdw_t K_YDEN  = sdw_t'(160 * MIC_L);
    localparam sdw_t K_FX    = sdw_t'(FX);
    localparam sdw_t K_FY    = sdw_t'(FY);
    localparam sdw_t K_CX    = sdw_t'(CX);
    localparam sdw_t K_CY    = sdw_t'(CY);
    localparam sdw_t K_TEN   = sdw_t'(10);
    localparam sdw_t K_W     = sdw_t'(IMG_W);
    localparam sdw_t K_WMAX  = sdw_t'(IMG_W - 1);
    localparam sdw_t K_HMAX  = sdw_t'(IMG_H - 1);

    typedef enum logic [3:0] {S_IDLE, S_DIST, S_R, S_X, S_Y, S_ZSQ, S_SQRT, S_U, S_V, S_OUT} state_t;
    state_t state;

    logic [2:0]    idx;
    logic [1:0]    div_phase;
    logic [CW-1:0] cnt;
    sdw_t          lag_reg [0:5];
    sdw_t          d_reg [0:5];
    sdw_t          r_reg, x_reg, y_reg, z_reg, u_reg, zsq_reg;
    logic [HW-1:0] root;
    logic [DW-1:0] rem, quo, dvs;
    logic          dneg;

    sdw_t lag_ext [0:5];
    sdw_t sq [0:5];
    genvar gi;
    generate
        for (gi = 0; gi < 6; gi++) begin : g_ch
            assign lag_ext[gi] = {{(DW-LAG_W){lag_in[gi*LAG_W+LAG_W-1]}}, lag_in[gi*LAG_W +: LAG_W]};
            assign sq[gi]      = d_reg[gi] * d_reg[gi];
        end
    endgenerate

    sdw_t r_lin, x_lin, y_lin, r2;
    assign r_lin = d_reg[0] - d_reg[2] + d_reg[3] - d_reg[5];
    assign x_lin = d_reg[2] - d_reg[0] + d_reg[3] - d_reg[5];
    assign y_lin = d_reg[4] - d_reg[1] + d_reg[5] - d_reg[0] + d_reg[3] - d_reg[2];
    assign r2    = r_reg + r_reg;

    // Operand selection for the single shared divider.
    sdw_t num_sel, den_sel;
    always_comb begin
        num_sel = '0;
        den_sel = '0;
        case (state)
            S_DIST: begin num_sel = K_SCALE * lag_reg[idx]; den_sel = K_FS; end
            S_R:    begin num_sel = sq[5] - sq[3] + sq[2] - sq[0]; den_sel = r_lin + r_lin; end
            S_X:    begin num_sel = r2 * x_lin + sq[2] - sq[0] + sq[3] - sq[5]; den_sel = K_XDEN; end
            S_Y:    begin
                num_sel = r2 * y_lin + sq[4] - sq[1] + sq[5] - sq[0] + sq[3] - sq[2];
                den_sel = K_YDEN;
            end
            S_U:    begin num_sel = K_FX * x_reg + K_CX * z_reg; den_sel = z_reg; end
            S_V:    begin num_sel = K_FY * y_reg + K_CY * z_reg; den_sel = z_reg; end
            default: ;
        endcase
    end

    logic [DW-1:0] num_mag, den_mag, q_fix;
    logic [DW:0]   trial;
    sdw_t          q_s;
    assign num_mag = num_sel[DW-1] ? -num_sel : num_sel;
    assign den_mag = den_sel[DW-1] ? -den_sel : den_sel;
    assign trial   = {rem, quo[DW-1]} - {1'b0, dvs};
    assign q_fix   = dneg ? -quo : quo;
    assign q_s     = sdw_t'(q_fix);

    sdw_t rd10, zsq_val;
    assign rd10    = r_reg / K_TEN;
    assign zsq_val = rd10 * rd10 - x_reg * x_reg - y_reg * y_reg;

    logic [HW-1:0] trial_root, root_next;
    logic [DW-1:0] trial_sq;
    assign trial_root = root | (HW'(1) << cnt);
    assign trial_sq   = {{(DW-HW){1'b0}}, trial_root} * {{(DW-HW){1'b0}}, trial_root};
    assign root_next  = (trial_sq <= $unsigned(zsq_reg)) ? trial_root : root;

    sdw_t u_sat, v_sat;
    logic frame_err;
    always_comb begin
`ifdef TDOA_PIXEL_CLAMP_EN
        u_sat     = (u_reg < 0) ? '0 : (u_reg > K_WMAX) ? K_WMAX : u_reg;
        v_sat     = (q_s < 0) ? '0 : (q_s > K_HMAX) ? K_HMAX : q_s;
        frame_err = 1'b0;
`else
        u_sat     = u_reg;
        v_sat     = q_s;
        frame_err = (u_reg < 0) || (u_reg > K_WMAX) || (q_s < 0) || (q_s > K_HMAX);
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_u     <= '0;
            out_v     <= '0;
            out_err   <= 1'b0;
            err_code  <= 2'd0;
            idx       <= '0;
            div_phase <= '0;
            cnt       <= '0;
            rem       <= '0;
            quo       <= '0;
            dvs       <= '0;
            dneg      <= 1'b0;
            r_reg     <= '0;
            x_reg     <= '0;
            y_reg     <= '0;
            z_reg     <= '0;
            u_reg     <= '0;
            zsq_reg   <= '0;
            root      <= '0;
            for (int i = 0; i < 6; i++) begin
                lag_reg[i] <= '0;
                d_reg[i]   <= '0;
            end
        end else begin
            case (state)
                S_IDLE: if (in_valid && in_ready) begin
                    for (int i = 0; i < 6; i++) lag_reg[i] <= lag_ext[i];
                    in_ready  <= 1'b0;
                    idx       <= '0;
                    div_phase <= '0;
                    state     <= S_DIST;
                end
                S_ZSQ: if (zsq_val < 0) begin
                    out_valid <= 1'b1; out_err <= 1'b1; err_code <= 2'd2;
                    out_u <= '0; out_v <= '0; state <= S_OUT;
                end else begin
                    zsq_reg <= zsq_val;
                    root    <= '0;
                    cnt     <= CW'(HW - 1);
                    state   <= S_SQRT;
                end
                S_SQRT: begin
                    root  <= root_next;
                    z_reg <= sdw_t'({{(DW-HW){1'b0}}, root_next});
                    cnt   <= cnt - 1'b1;
                    if (cnt == '0) state <= S_U;
                end
                S_OUT: if (out_ready) begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= S_IDLE;
                end
                S_DIST, S_R, S_X, S_Y, S_U, S_V: begin
                    case (div_phase)
                        2'd0: if (den_sel == '0) begin
                            out_valid <= 1'b1; out_err <= 1'b1; err_code <= 2'd1;
                            out_u <= '0; out_v <= '0; state <= S_OUT;
                        end else begin
                            rem       <= '0;
                            quo       <= num_mag;
                            dvs       <= den_mag;
                            dneg      <= num_sel[DW-1] ^ den_sel[DW-1];
                            cnt       <= '0;
                            div_phase <= 2'd1;
                        end
                        2'd1: begin
                            // Restoring step: keep the shifted remainder unless the trial subtract fits.
                            if (!trial[DW]) begin
                                rem <= trial[DW-1:0];
                                quo <= {quo[DW-2:0], 1'b1};
                            end else begin
                                rem <= {rem[DW-2:0], quo[DW-1]};
                                quo <= {quo[DW-2:0], 1'b0};
                            end
                            cnt <= cnt + 1'b1;
                            if (cnt == CW'(DW - 1)) div_phase <= 2'd2;
                        end
                        default: begin
                            div_phase <= 2'd0;
                            case (state)
                                S_DIST: begin
                                    d_reg[idx] <= q_s;
                                    if (idx == 3'd5) state <= S_R;
                                    else idx <= idx + 3'd1;
                                end
                                S_R: begin r_reg <= sdw_t'(quo); state <= S_X; end
                                S_X: begin x_reg <= q_s; state <= S_Y; end
                                S_Y: begin y_reg <= q_s; state <= S_ZSQ; end
                                S_U: begin u_reg <= K_W - q_s; state <= S_V; end
                                default: begin
                                    out_valid <= 1'b1;
                                    state     <= S_OUT;
                                    if (frame_err) begin
                                        out_err <= 1'b1; err_code <= 2'd3;
                                        out_u <= '0; out_v <= '0;
                                    end else begin
                                        out_err <= 1'b0; err_code <= 2'd0;
                                        out_u <= u_sat[OW-1:0]; out_v <= v_sat[OW-1:0];
                                    end
                                end
                            endcase
                        end
                    endcase
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_tdoa_pixel_locator.sv
// Directed bench for tdoa_pixel_locator: scoreboard of arithmetic-model results vs DUT output.
`timescale 1ns/1ps
module tb_tdoa_pixel_locator;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic              in_valid = 1'b0, out_ready = 1'b1;
    logic              in_ready, out_valid, out_err;
    logic [35:0]       lag_in = '0;
    logic signed [11:0] out_u, out_v;
    logic [1:0]        err_code;

    logic              in_valid2 = 1'b0, out_ready2 = 1'b1;
    logic              in_ready2, out_valid2, out_err2;
    logic signed [11:0] out_u2, out_v2;
    logic [1:0]        err_code2;

    tdoa_pixel_locator dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .lag_in(lag_in),
        .out_valid(out_valid), .out_ready(out_ready), .out_u(out_u), .out_v(out_v),
        .out_err(out_err), .err_code(err_code));

    tdoa_pixel_locator #(.CX(600)) dut_cx (
        .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2), .lag_in(lag_in),
        .out_valid(out_valid2), .out_ready(out_ready2), .out_u(out_u2), .out_v(out_v2),
        .out_err(out_err2), .err_code(err_code2));

    typedef struct { int u; int v; logic err; int code; } exp_t;
    exp_t sb[$];
    int n_assert = 0, n_fail = 0, acc_cnt = 0;

    always @(posedge clk) if (in_valid && in_ready) acc_cnt <= acc_cnt + 1;

    initial begin
        #900000;
        $display("FAIL watchdog expired observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp_v);
        n_assert++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    function automatic logic [35:0] pk(input int a0, a1, a2, a3, a4, a5);
        return {6'(a5), 6'(a4), 6'(a3), 6'(a2), 6'(a1), 6'(a0)};
    endfunction

    // Straight integer evaluation of the position/projection equations.
    function automatic exp_t model(input int a0, a1, a2, a3, a4, a5, input int cx);
        int lag[6];
        int d[6];
        int rden, r, x, y, rd, zsq, z, u, v;
        exp_t e;
        lag = '{a0, a1, a2, a3, a4, a5};
        e.u = 0; e.v = 0; e.err = 1'b1; e.code = 0;
        for (int i = 0; i < 6; i++) d[i] = 340 * lag[i] * 10000 / 93750;
        rden = 2 * (d[0] - d[2] + d[3] - d[5]);
        if (rden == 0) begin e.code = 1; return e; end
        r = (d[5]*d[5] - d[3]*d[3] + d[2]*d[2] - d[0]*d[0]) / rden;
        if (r < 0) r = -r;
        x = (2*r*(d[2]-d[0]+d[3]-d[5]) + d[2]*d[2] - d[0]*d[0] + d[3]*d[3] - d[5]*d[5]) / 27712;
        y = (2*r*(d[4]-d[1]+d[5]-d[0]+d[3]-d[2]) + d[4]*d[4] - d[1]*d[1] + d[5]*d[5]
             - d[0]*d[0] + d[3]*d[3] - d[2]*d[2]) / 32000;
        rd = r / 10;
        zsq = rd*rd - x*x - y*y;
        if (zsq < 0) begin e.code = 2; return e; end
        z = 0;
        while (longint'(z + 1) * longint'(z + 1) <= longint'(zsq)) z++;
        if (z == 0) begin e.code = 1; return e; end
        u = 480 - (437*x + cx*z) / z;
        v = (330*y + 145*z) / z;
`ifdef TDOA_PIXEL_CLAMP_EN
        if (u < 0) u = 0;
        if (u > 479) u = 479;
        if (v < 0) v = 0;
        if (v > 271) v = 271;
`else
        if (u < 0 || u > 479 || v < 0 || v > 271) begin e.code = 3; return e; end
`endif
        e.u = u; e.v = v; e.err = 1'b0; e.code = 0;
        return e;
    endfunction

    task automatic push(input int u, input int v, input logic err, input int code);
        exp_t e;
        e.u = u; e.v = v; e.err = err; e.code = code;
        sb.push_back(e);
    endtask

    task automatic send(input string tag, input logic [35:0] lags);
        int t = 0;
        while (!in_ready && t < 2000) begin tick(); t++; end
        check({tag, "_ready_before"}, in_ready, 1);
        lag_in = lags;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check({tag, "_ready_after_accept"}, in_ready, 0);
    endtask

    task automatic get_result(input string tag, input bit do_ack, input bit drop_iv);
        exp_t e;
        int t = 0;
        while (!out_valid && t < 3000) begin tick(); t++; end
        check({tag, "_valid"}, out_valid, 1);
        check({tag, "_latency"}, (t <= 413), 1);
        check({tag, "_sb_nonempty"}, (sb.size() != 0), 1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check({tag, "_u"}, out_u, e.u);
            check({tag, "_v"}, out_v, e.v);
            check({tag, "_err"}, out_err, e.err);
            check({tag, "_code"}, err_code, e.code);
            $display("TXN %s u=%0d v=%0d err=%0d code=%0d (exp %0d %0d %0d %0d) cycles=%0d",
                     tag, out_u, out_v, out_err, err_code, e.u, e.v, e.err, e.code, t);
        end
        if (do_ack) begin
            if (drop_iv) in_valid = 1'b0;
            out_ready = 1'b1;
            tick();
            check({tag, "_valid_drop"}, out_valid, 0);
            check({tag, "_ready_back"}, in_ready, 1);
        end
    endtask

    task automatic run_vec(input string tag, input int a0, a1, a2, a3, a4, a5);
        sb.push_back(model(a0, a1, a2, a3, a4, a5, 242));
        send(tag, pk(a0, a1, a2, a3, a4, a5));
        get_result(tag, 1'b1, 1'b0);
    endtask

    initial begin
        int acc0, bad, t;
        exp_t e;
        repeat (3) tick();
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_u", out_u, 0);
        check("rst_out_v", out_v, 0);
        check("rst_out_err", out_err, 0);
        check("rst_err_code", err_code, 0);
        rst = 1'b0;
        tick();

        // Single-lag source straight ahead.
        push(238, 145, 1'b0, 0);
        send("t1", pk(1, 0, 0, 0, 0, 0));
        get_result("t1", 1'b1, 1'b0);

        // All-zero lags: range divisor is zero.
        push(0, 0, 1'b1, 1);
        send("t2", pk(0, 0, 0, 0, 0, 0));
        get_result("t2", 1'b1, 1'b0);

        run_vec("m_neg_zsq", 31, 0, 0, 0, 0, 0);
        run_vec("m_offaxis", 10, 0, 3, 0, 6, 0);
        run_vec("m_vframe", 10, 0, 3, 0, 0, 0);
        run_vec("m_mixed", -2, 0, 0, 0, 0, 1);

        // Backpressure: outputs hold, a busy-time in_valid pulse is dropped.
        acc0 = acc_cnt;
        out_ready = 1'b0;
        push(238, 145, 1'b0, 0);
        send("t3", pk(1, 0, 0, 0, 0, 0));
        get_result("t3", 1'b0, 1'b0);
        bad = 0;
        for (int k = 0; k < 50; k++) begin
            if (k == 20) begin lag_in = pk(0, 0, 0, 0, 0, 0); in_valid = 1'b1; end
            tick();
            in_valid = 1'b0;
            if (!(out_valid === 1'b1 && out_u === 12'sd238 && out_v === 12'sd145 &&
                  out_err === 1'b0 && in_ready === 1'b0)) bad++;
        end
        check("t3_hold_stable", bad, 0);
        out_ready = 1'b1;
        tick();
        check("t3_valid_drop", out_valid, 0);
        check("t3_ready_back", in_ready, 1);
        check("t3_accepts", acc_cnt - acc0, 1);
        bad = 0;
        for (int k = 0; k < 20; k++) begin tick(); if (out_valid !== 1'b0) bad++; end
        check("t3_no_extra_xfer", bad, 0);

        // Reset during the square-root phase.
        send("t4", pk(1, 0, 0, 0, 0, 0));
        repeat (312) tick();
        check("t4_busy_before_rst", in_ready, 0);
        rst = 1'b1;
        tick();
        check("t4_rst_valid", out_valid, 0);
        check("t4_rst_ready", in_ready, 1);
        check("t4_rst_err", out_err, 0);
        rst = 1'b0;
        bad = 0;
        for (int k = 0; k < 450; k++) begin tick(); if (out_valid !== 1'b0) bad++; end
        check("t4_no_partial", bad, 0);
        push(238, 145, 1'b0, 0);
        send("t4b", pk(1, 0, 0, 0, 0, 0));
        get_result("t4b", 1'b1, 1'b0);

        // Principal point pushed past the frame edge.
        lag_in = pk(1, 0, 0, 0, 0, 0);
        in_valid2 = 1'b1;
        tick();
        in_valid2 = 1'b0;
        t = 0;
        while (!out_valid2 && t < 3000) begin tick(); t++; end
        check("t5_valid", out_valid2, 1);
`ifdef TDOA_PIXEL_CLAMP_EN
        e.u = 0; e.v = 145; e.err = 1'b0; e.code = 0;
`else
        e.u = 0; e.v = 0; e.err = 1'b1; e.code = 3;
`endif
        check("t5_u", out_u2, e.u);
        check("t5_v", out_v2, e.v);
        check("t5_err", out_err2, e.err);
        check("t5_code", err_code2, e.code);
        $display("TXN t5 u=%0d v=%0d err=%0d code=%0d", out_u2, out_v2, out_err2, err_code2);

        // Back-to-back with in_valid held high.
        tick();
        acc0 = acc_cnt;
        push(238, 145, 1'b0, 0);
        push(238, 145, 1'b0, 0);
        lag_in = pk(1, 0, 0, 0, 0, 0);
        in_valid = 1'b1;
        tick();
        get_result("t6a", 1'b1, 1'b0);
        tick();
        get_result("t6b", 1'b1, 1'b1);
        repeat (5) tick();
        check("t6_accepts", acc_cnt - acc0, 2);
        check("t6_sb_empty", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
